// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcodes, state encodings, datapath mux codes and the decoded control vector.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // pc_write and ir_write are raw here; the top gates them with mem_ready.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, illegal_op
    );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational Moore decode: current state -> raw datapath control vector.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            // Branch target is precomputed while the opcode is being decoded.
            S_DECODE: ctrl.alu_src_b = SRCB_SEXT_SH2;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register, next-state logic with
// mem_ready stalls, illegal-opcode pulse and mem_ready/zero gating of PC/IR loads.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t state_reg, state_next;
    logic   illegal_reg, illegal_next;
    ctrl_t  ctrl;
    logic   mem_gate;

    always_comb begin
        state_next   = S_FETCH;
        illegal_next = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
                illegal_next = !is_legal_op(bus.opcode);
            end
            S_MEMADR: state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    // Only FETCH asserts the raw IR/PC loads unconditionally, so gating there covers the stall.
    assign mem_gate = (state_reg != S_FETCH) || bus.mem_ready;

    assign bus.pc_en      = (ctrl.pc_write && mem_gate) || (ctrl.pc_write_cond && bus.zero);
    assign bus.ir_write   = ctrl.ir_write && mem_gate;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.state      = state_reg;
    assign bus.illegal_op = illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM: walks each instruction
// class through its state sequence and checks decoded controls per state.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        bus.opcode    = 6'b100011;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", bus.state, 0);
        check("rst_illegal", bus.illegal_op, 0);
        check("rst_mem_read", bus.mem_read, 1);
        check("rst_srcb", bus.alu_src_b, 2'b01);
        check("rst_pc_en", bus.pc_en, 1);
        check("rst_ir_write", bus.ir_write, 1);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_reg_write", bus.reg_write, 0);
        tick();
        check("rst_hold_state", bus.state, 0);
        @(negedge clk) rst_n = 1'b1;

        // LW: 0,1,2,3,4,0
        tick();
        check("lw_decode", bus.state, 1);
        check("lw_dec_srcb", bus.alu_src_b, 2'b11);
        check("lw_dec_pc_en", bus.pc_en, 0);
        tick();
        check("lw_memadr", bus.state, 2);
        check("lw_adr_srcb", bus.alu_src_b, 2'b10);
        check("lw_adr_srca", bus.alu_src_a, 1);
        tick();
        check("lw_memrd", bus.state, 3);
        check("lw_rd_mem_read", bus.mem_read, 1);
        check("lw_rd_i_or_d", bus.i_or_d, 1);
        tick();
        check("lw_memwb", bus.state, 4);
        check("lw_wb_reg_write", bus.reg_write, 1);
        check("lw_wb_mem_to_reg", bus.mem_to_reg, 1);
        check("lw_wb_reg_dst", bus.reg_dst, 0);
        tick();
        check("lw_done", bus.state, 0);

        // SW with two wait cycles in MEMWR
        bus.opcode = 6'b101011;
        tick();
        check("sw_decode", bus.state, 1);
        tick();
        check("sw_memadr", bus.state, 2);
        bus.mem_ready = 1'b0;
        tick();
        check("sw_memwr1", bus.state, 5);
        check("sw_wr1_mem_write", bus.mem_write, 1);
        check("sw_wr1_reg_write", bus.reg_write, 0);
        tick();
        check("sw_memwr2", bus.state, 5);
        check("sw_wr2_mem_write", bus.mem_write, 1);
        tick();
        check("sw_memwr3", bus.state, 5);
        check("sw_wr3_mem_write", bus.mem_write, 1);
        bus.mem_ready = 1'b1;
        #1;
        check("sw_wr3_reg_write", bus.reg_write, 0);
        tick();
        check("sw_done", bus.state, 0);

        // FETCH stall
        bus.mem_ready = 1'b0;
        #1;
        check("stall_pc_en", bus.pc_en, 0);
        check("stall_ir_write", bus.ir_write, 0);
        check("stall_mem_read", bus.mem_read, 1);
        tick();
        check("stall_state", bus.state, 0);
        bus.mem_ready = 1'b1;

        // BEQ taken, then not taken
        bus.opcode = 6'b000100;
        for (int run = 0; run < 2; run++) begin
            bus.zero = (run == 0);
            tick();
            check("beq_decode", bus.state, 1);
            tick();
            check("beq_branch", bus.state, 8);
            check("beq_pc_en", bus.pc_en, (run == 0) ? 1 : 0);
            check("beq_alu_op", bus.alu_op, 2'b01);
            check("beq_pc_source", bus.pc_source, 2'b01);
            check("beq_reg_write", bus.reg_write, 0);
            tick();
            check("beq_done", bus.state, 0);
        end
        bus.zero = 1'b0;

        // R-type
        bus.opcode = 6'b000000;
        tick();
        tick();
        check("r_exec", bus.state, 6);
        check("r_exec_srcb", bus.alu_src_b, 2'b00);
        check("r_exec_alu_op", bus.alu_op, 2'b10);
        tick();
        check("r_rwb", bus.state, 7);
        check("r_rwb_reg_dst", bus.reg_dst, 1);
        check("r_rwb_reg_write", bus.reg_write, 1);
        check("r_rwb_mem_to_reg", bus.mem_to_reg, 0);
        tick();
        check("r_done", bus.state, 0);

        // ADDI
        bus.opcode = 6'b001000;
        tick();
        tick();
        check("addi_ex", bus.state, 9);
        check("addi_ex_srcb", bus.alu_src_b, 2'b10);
        tick();
        check("addi_wb", bus.state, 10);
        check("addi_wb_reg_dst", bus.reg_dst, 0);
        check("addi_wb_reg_write", bus.reg_write, 1);
        tick();
        check("addi_done", bus.state, 0);

        // Jump
        bus.opcode = 6'b000010;
        tick();
        tick();
        check("j_jump", bus.state, 11);
        check("j_pc_source", bus.pc_source, 2'b10);
        check("j_pc_en", bus.pc_en, 1);
        tick();
        check("j_done", bus.state, 0);

        // Illegal opcode: one-cycle pulse
        bus.opcode = 6'b111111;
        tick();
        check("ill_decode", bus.state, 1);
        check("ill_pre_pulse", bus.illegal_op, 0);
        tick();
        check("ill_back_fetch", bus.state, 0);
        check("ill_pulse", bus.illegal_op, 1);
        bus.opcode = 6'b100011;
        tick();
        check("ill_pulse_end", bus.illegal_op, 0);
        tick();
        check("ill_next_memadr", bus.state, 2);

        // Reset mid-MEMRD, away from any clock edge
        tick();
        check("mid_memrd", bus.state, 3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_state", bus.state, 0);
        check("mid_rst_reg_write", bus.reg_write, 0);
        check("mid_rst_mem_write", bus.mem_write, 0);
        check("mid_rst_mem_read", bus.mem_read, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_decode", bus.state, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
